// File: rtl/reg_file_16.sv
// 16-entry register bank with one synchronous write port and two bypassed combinational
// read ports, plus a valid/ready engine that streams all 16 registers out for debug display.

module mux_16to1 #(
    parameter int WIDTH = 32
) (
    input  logic [15:0][WIDTH-1:0] data_i,
    input  logic [3:0]             sel_i,
    output logic [WIDTH-1:0]       data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < 16; i++) begin
            if (sel_i == 4'(i)) begin
                data_o = data_i[i];
            end
        end
    end

endmodule

module reg_file_16 #(
    parameter int WIDTH    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ena,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [3:0]       rd_addr0,
    output logic [WIDTH-1:0] rd_data0,
    input  logic [3:0]       rd_addr1,
    output logic [WIDTH-1:0] rd_data1,
    input  logic             dump_start,
    output logic             dump_busy,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [3:0]       dump_addr,
    output logic [WIDTH-1:0] dump_data,
    output logic             dump_done
);

    localparam bit ZERO_ON = (ZERO_REG != 0);

    // Dump handshake: a beat (dump_addr/dump_data) transfers on any rising clk edge where
    // dump_valid && dump_ready; while dump_ready is low the beat is held.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } dump_state_e;

    logic [15:0][WIDTH-1:0] regs_q;
    logic [15:0][WIDTH-1:0] regs_d;
    logic                   wr_take;
    logic [WIDTH-1:0]       mux0;
    logic [WIDTH-1:0]       mux1;

    dump_state_e state_q;
    logic [3:0]  cnt_q;
    logic        valid_q;
    logic        busy_q;
    logic        done_q;

    assign wr_take = wr_ena && !(ZERO_ON && (wr_addr == 4'd0));

    always_comb begin
        regs_d = regs_q;
        if (wr_take) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    mux_16to1 #(.WIDTH(WIDTH)) u_rd0_mux (
        .data_i (regs_q),
        .sel_i  (rd_addr0),
        .data_o (mux0)
    );

    mux_16to1 #(.WIDTH(WIDTH)) u_rd1_mux (
        .data_i (regs_q),
        .sel_i  (rd_addr1),
        .data_o (mux1)
    );

    // The suppressed zero register wins over the write-first bypass.
    always_comb begin
        rd_data0 = mux0;
        if (ZERO_ON && (rd_addr0 == 4'd0)) begin
            rd_data0 = '0;
        end else if (wr_ena && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
    end

    always_comb begin
        rd_data1 = mux1;
        if (ZERO_ON && (rd_addr1 == 4'd0)) begin
            rd_data1 = '0;
        end else if (wr_ena && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump_start) begin
                        state_q <= RUN;
                        cnt_q   <= 4'd0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (dump_ready) begin
                        if (cnt_q == 4'd15) begin
                            state_q <= DONE;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Dump data is the live stored value: no write bypass on this path.
    mux_16to1 #(.WIDTH(WIDTH)) u_dump_mux (
        .data_i (regs_q),
        .sel_i  (cnt_q),
        .data_o (dump_data)
    );

    assign dump_addr  = cnt_q;
    assign dump_valid = valid_q;
    assign dump_busy  = busy_q;
    assign dump_done  = done_q;

endmodule

// File: tb/tb_reg_file_16.sv
// Bench for reg_file_16: two instances (ZERO_REG=1 and ZERO_REG=0) on shared stimulus,
// checked each cycle against an array/queue model plus hand-computed literal expectations.

module tb_reg_file_16;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         wr_ena;
    logic [3:0]   wr_addr;
    logic [W-1:0] wr_data;
    logic [3:0]   rd_addr0;
    logic [3:0]   rd_addr1;
    logic         dump_start;
    logic         dump_ready;

    logic [W-1:0] z_rd0, z_rd1, z_dd, n_rd0, n_rd1, n_dd;
    logic [3:0]   z_addr, n_addr;
    logic         z_busy, z_valid, z_done, n_busy, n_valid, n_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit check_en = 1'b0;

    logic [W-1:0] m_reg [2][16];
    bit           m_busy;
    int           m_beat;
    logic [3:0]   exp_q[$];
    logic [W-1:0] obs_data[$];
    int           done_cnt;

    reg_file_16 #(.WIDTH(W), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(z_rd0), .rd_addr1(rd_addr1), .rd_data1(z_rd1),
        .dump_start(dump_start), .dump_busy(z_busy), .dump_valid(z_valid),
        .dump_ready(dump_ready), .dump_addr(z_addr), .dump_data(z_dd), .dump_done(z_done)
    );

    reg_file_16 #(.WIDTH(W), .ZERO_REG(0)) u_dut_nz (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr0(rd_addr0), .rd_data0(n_rd0), .rd_addr1(rd_addr1), .rd_data1(n_rd1),
        .dump_start(dump_start), .dump_busy(n_busy), .dump_valid(n_valid),
        .dump_ready(dump_ready), .dump_addr(n_addr), .dump_data(n_dd), .dump_done(n_done)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check helper ----------------
    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Index 0 models the ZERO_REG=1 instance, index 1 the ZERO_REG=0 instance.
    function automatic logic [W-1:0] m_read(input int k, input logic [3:0] a);
        if (k == 0 && a == 4'd0) return '0;
        if (wr_ena && a == wr_addr) return wr_data;
        return m_reg[k][a];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                m_reg[0][i] = '0;
                m_reg[1][i] = '0;
            end
            m_busy = 1'b0;
            m_beat = 0;
            exp_q.delete();
        end else begin
            if (wr_ena) begin
                if (wr_addr != 4'd0) m_reg[0][wr_addr] = wr_data;
                m_reg[1][wr_addr] = wr_data;
            end
            if (!m_busy) begin
                if (dump_start) begin
                    m_busy = 1'b1;
                    m_beat = 0;
                    for (int i = 0; i < 16; i++) exp_q.push_back(4'(i));
                end
            end else if (m_beat == 16) begin
                m_busy = 1'b0;
            end else if (dump_ready) begin
                m_beat++;
            end
        end
    end

    // ---------------- compare process (scoreboard) ----------------
    always @(negedge clk) begin
        if (check_en && !rst) begin
            logic m_valid, m_done;
            logic [3:0] a;
            m_valid = m_busy && (m_beat < 16);
            m_done  = m_busy && (m_beat == 16);
            chk("z_rd0", z_rd0, m_read(0, rd_addr0));
            chk("z_rd1", z_rd1, m_read(0, rd_addr1));
            chk("n_rd0", n_rd0, m_read(1, rd_addr0));
            chk("n_rd1", n_rd1, m_read(1, rd_addr1));
            chk("z_busy", W'(z_busy), W'(m_busy));
            chk("n_busy", W'(n_busy), W'(m_busy));
            chk("z_valid", W'(z_valid), W'(m_valid));
            chk("n_valid", W'(n_valid), W'(m_valid));
            chk("z_done", W'(z_done), W'(m_done));
            chk("n_done", W'(n_done), W'(m_done));
            if (m_valid) begin
                chk("z_dump_addr", W'(z_addr), W'(m_beat));
                chk("n_dump_addr", W'(n_addr), W'(m_beat));
                chk("z_dump_data", z_dd, m_reg[0][m_beat]);
                chk("n_dump_data", n_dd, m_reg[1][m_beat]);
            end
            if (z_valid && dump_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL extra_beat: got addr %h, expected no beat", z_addr);
                end else begin
                    a = exp_q.pop_front();
                    chk("beat_order", W'(z_addr), W'(a));
                    obs_data.push_back(z_dd);
                end
            end
            if (z_done) done_cnt++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [W-1:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_ena  = 1'b0;
    endtask

    task automatic run_dump(input bit toggle_ready, input bit poke_start, output int busy_cycles);
        bit ended;
        obs_data.delete();
        done_cnt    = 0;
        busy_cycles = 0;
        ended       = 1'b0;
        dump_start  = 1'b1;
        step();
        dump_start  = 1'b0;
        for (int c = 0; c < 300 && !ended; c++) begin
            dump_ready = toggle_ready ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
            dump_start = poke_start && (c == 5);
            @(negedge clk);
            if (z_busy) busy_cycles++;
            else ended = 1'b1;
            step();
        end
        dump_start = 1'b0;
        dump_ready = 1'b0;
        if (!ended) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dump_timeout: got busy after 300 cycles, expected dump to finish");
        end
    endtask

    task automatic check_dump(input string name, input int exp_cycles, input int busy_cycles, input bit ramp);
        chk({name, "_cycles"}, W'(busy_cycles), W'(exp_cycles));
        chk({name, "_beats"}, W'(obs_data.size()), W'(16));
        chk({name, "_done_pulses"}, W'(done_cnt), W'(1));
        for (int i = 0; i < 16 && i < obs_data.size(); i++) begin
            chk({name, "_beat_data"}, obs_data[i], ramp ? W'(i) * 32'h11 : '0);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int cyc;
        wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        dump_start = 1'b0; dump_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", W'(z_busy), '0);
        chk("rst_valid", W'(z_valid), '0);
        chk("rst_done", W'(z_done), '0);
        chk("rst_addr", W'(z_addr), '0);
        chk("rst_data", z_dd, '0);
        repeat (2) step();
        rst = 1'b0;
        check_en = 1'b1;

        // All addresses read 0 on both ports after reset.
        for (int a = 0; a < 16; a++) begin
            rd_addr0 = 4'(a);
            rd_addr1 = 4'(15 - a);
            #2;
            chk("reset_rd0", z_rd0, '0);
            chk("reset_rd1", n_rd1, '0);
            step();
        end

        write_reg(4'd5, 32'hDEADBEEF);
        rd_addr0 = 4'd5;
        rd_addr1 = 4'd6;
        #2;
        chk("r5_port0", z_rd0, 32'hDEADBEEF);
        chk("r6_port1", z_rd1, 32'h0);
        step();

        // Same-cycle write and read of r7 on both ports.
        wr_ena = 1'b1; wr_addr = 4'd7; wr_data = 32'h12345678;
        rd_addr0 = 4'd7; rd_addr1 = 4'd7;
        #2;
        chk("bypass_p0", z_rd0, 32'h12345678);
        chk("bypass_p1", z_rd1, 32'h12345678);
        chk("bypass_nz_p1", n_rd1, 32'h12345678);
        step();
        wr_ena = 1'b0;
        #2;
        chk("r7_stored", z_rd1, 32'h12345678);

        // Register 0: suppressed on one instance, ordinary on the other.
        wr_ena = 1'b1; wr_addr = 4'd0; wr_data = 32'hFFFFFFFF;
        rd_addr0 = 4'd0; rd_addr1 = 4'd0;
        #2;
        chk("zr_write_cycle", z_rd0, 32'h0);
        chk("nz_write_cycle", n_rd0, 32'hFFFFFFFF);
        step();
        wr_ena = 1'b0;
        #2;
        chk("zr_after_write", z_rd1, 32'h0);
        chk("nz_after_write", n_rd1, 32'hFFFFFFFF);
        step();

        // Ramp pattern then a full-speed dump.
        for (int i = 0; i < 16; i++) write_reg(4'(i), W'(i) * 32'h11);
        run_dump(1'b0, 1'b0, cyc);
        check_dump("dump_full", 17, cyc, 1'b1);
        #2;
        chk("idle_after_dump", W'(z_busy), '0);

        // Throttled dump with a stray start request in the middle.
        run_dump(1'b1, 1'b1, cyc);
        check_dump("dump_throttled", 33, cyc, 1'b1);

        // Reset while beat 9 is on display.
        done_cnt   = 0;
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        repeat (9) step();
        dump_ready = 1'b0;
        #1;
        chk("pre_abort_addr", W'(z_addr), W'(9));
        check_en = 1'b0;
        rst = 1'b1;
        #1;
        chk("abort_valid", W'(z_valid), '0);
        chk("abort_busy", W'(z_busy), '0);
        chk("abort_done", W'(z_done), '0);
        rd_addr0 = 4'd9;
        rd_addr1 = 4'd15;
        #1;
        chk("abort_r9", z_rd0, '0);
        chk("abort_r15", n_rd1, '0);
        repeat (2) step();
        rst = 1'b0;
        check_en = 1'b1;
        for (int a = 0; a < 16; a++) begin
            rd_addr0 = 4'(a);
            rd_addr1 = 4'(a);
            #2;
            chk("post_rst_nz", n_rd0, '0);
            step();
        end
        chk("abort_no_done", W'(done_cnt), '0);

        run_dump(1'b0, 1'b0, cyc);
        check_dump("dump_zero", 17, cyc, 1'b0);

        repeat (2) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
